// File: rtl/chan_err_injector.sv
// Channel model between encoder and decoder: registers each symbol and XORs a mask in during bursts.
// Optional statistics counters are built only when CHAN_STATS_EN is defined.
module chan_err_injector #(
    parameter int W      = 2,
    parameter int CNT_W  = 16,
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [3:0]        cfg_burst_len,
    input  logic [W-1:0]      cfg_mask,
    input  logic [7:0]        cfg_thresh,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic              clr_stats,
    input  logic              in_valid,
    input  logic [W-1:0]      in_sym,
    output logic              out_valid,
    output logic [W-1:0]      out_sym,
    output logic              err_flag,
    output logic [CNT_W-1:0]  sym_ct,
    output logic [CNT_W-1:0]  bad_bit_ct,
    output logic              dbg_state
);
    localparam logic [0:0]        S_IDLE   = 1'b0;
    localparam logic [0:0]        S_BURST  = 1'b1;
    localparam logic [LFSR_W-1:0] SEED_DEF = 16'hACE1;
    // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [LFSR_W-1:0] TAPS     = 16'hB400;

    logic [1:0]        sh_mode;
    logic [CNT_W-1:0]  sh_period;
    logic [3:0]        sh_burst_len;
    logic [W-1:0]      sh_mask;
    logic [7:0]        sh_thresh;

    logic [0:0]        state;
    logic [3:0]        remaining;
    logic [CNT_W-1:0]  phase;
    logic [CNT_W-1:0]  phase_next;
    logic [CNT_W-1:0]  idx;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] seed_eff;
    logic              armed;
    logic              trig;
    logic              corrupt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_mode      <= 2'd0;
            sh_period    <= '0;
            sh_burst_len <= 4'd1;
            sh_mask      <= '0;
            sh_thresh    <= 8'd0;
        end else if (cfg_load) begin
            sh_mode      <= cfg_mode;
            sh_period    <= cfg_period;
            sh_burst_len <= (cfg_burst_len == 4'd0) ? 4'd1 : cfg_burst_len;
            sh_mask      <= cfg_mask;
            sh_thresh    <= cfg_thresh;
        end
    end

    always_comb begin
        trig = 1'b0;
        case (sh_mode)
            2'd1:    trig = (sh_period != '0) && (phase == '0) && (idx != '0);
            2'd2:    trig = (lfsr[7:0] < sh_thresh);
            2'd3:    trig = (sh_period != '0) && armed && (idx == sh_period);
            default: trig = 1'b0;
        endcase
    end

    assign corrupt    = in_valid && ((state == S_BURST) || trig);
    assign phase_next = ((sh_period == '0) || (phase == sh_period - CNT_W'(1))) ? '0 : phase + CNT_W'(1);
    assign lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign seed_eff   = (cfg_seed == '0) ? SEED_DEF : cfg_seed;

    // cfg_load restarts everything after the current symbol used the old settings
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= 4'd0;
            phase     <= '0;
            idx       <= '0;
            lfsr      <= SEED_DEF;
            armed     <= 1'b1;
        end else if (cfg_load) begin
            state     <= S_IDLE;
            remaining <= 4'd0;
            phase     <= '0;
            idx       <= '0;
            lfsr      <= seed_eff;
            armed     <= 1'b1;
        end else if (in_valid) begin
            phase <= phase_next;
            lfsr  <= lfsr_next;
            idx   <= clr_stats ? '0 : idx + CNT_W'(1);
            if (state == S_IDLE) begin
                if (trig) begin
                    if (sh_mode == 2'd3) armed <= 1'b0;
                    if (sh_burst_len > 4'd1) begin
                        state     <= S_BURST;
                        remaining <= sh_burst_len - 4'd1;
                    end
                end
            end else begin
                if (remaining == 4'd1) state <= S_IDLE;
                remaining <= remaining - 4'd1;
            end
        end else if (clr_stats) begin
            idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sym   <= '0;
            err_flag  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            err_flag  <= corrupt && (sh_mask != '0);
            if (in_valid) out_sym <= corrupt ? (in_sym ^ sh_mask) : in_sym;
        end
    end

    assign dbg_state = state;

`ifdef CHAN_STATS_EN
    function automatic logic [CNT_W-1:0] popcount(input logic [W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    logic [CNT_W-1:0] bad_ct;
    logic [CNT_W:0]   bad_sum;

    assign bad_sum = {1'b0, bad_ct} + {1'b0, popcount(sh_mask)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_ct <= '0;
        end else if (cfg_load || clr_stats) begin
            bad_ct <= '0;
        end else if (corrupt) begin
            bad_ct <= bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
        end
    end

    assign sym_ct     = idx;
    assign bad_bit_ct = bad_ct;
`else
    assign sym_ct     = '0;
    assign bad_bit_ct = '0;
`endif

endmodule
